// File: rtl/umidificador_pwm.sv
// Vaporizer PWM actuator: soft duty ramps plus minimum on/off dwell so a
// chattering humidity controller cannot short-cycle the humidifier.
module umidificador_pwm #(
  parameter int TICK_DIV  = 1000,
  parameter int MIN_ON    = 4,
  parameter int MIN_OFF   = 4,
  parameter int RAMP_STEP = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       liga,
  input  logic [6:0] potencia,
  output logic       pwm_out,
  output logic       ativo,
  output logic       bloqueado,
  output logic [6:0] duty_atual,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    SUBINDO   = 3'd1,
    LIGADO    = 3'd2,
    DESCENDO  = 3'd3
  } estado_e;

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int DW     = (DW_MAX > 0) ? $clog2(DW_MAX + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DW_SAT     = DW'(DW_MAX);
  localparam logic [DW-1:0] MIN_ON_C   = DW'(MIN_ON);
  localparam logic [DW-1:0] MIN_OFF_C  = DW'(MIN_OFF);
  localparam logic [7:0]    STEP       = 8'(RAMP_STEP);

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    pwm_cnt_q, pwm_cnt_d;
  estado_e       state_q, state_d;
  logic [6:0]    duty_q, duty_d;
  logic [DW-1:0] on_q, on_d, off_q, off_d;
  logic          pwm_q;

  logic          tick, period_end;
  logic [6:0]    alvo7, toward, ramp_down, first_duty;
  logic [7:0]    alvo8, duty8, up_sum, dn_lim;
  logic [DW-1:0] on_inc, off_inc;

  assign tick       = (presc_q == PRESC_LAST);
  assign period_end = tick && (pwm_cnt_q == 7'd99);
  assign presc_d    = tick ? '0 : presc_q + 1'b1;
  assign pwm_cnt_d  = !tick ? pwm_cnt_q : ((pwm_cnt_q == 7'd99) ? 7'd0 : pwm_cnt_q + 7'd1);

  // 8-bit intermediates: alvo and duty are <= 100 and the step <= 100, so sums stay below 256.
  assign alvo7      = (potencia > 7'd100) ? 7'd100 : potencia;
  assign alvo8      = {1'b0, alvo7};
  assign duty8      = {1'b0, duty_q};
  assign up_sum     = duty8 + STEP;
  assign dn_lim     = alvo8 + STEP;
  assign toward     = (duty8 < alvo8) ? ((up_sum > alvo8) ? alvo7 : 7'(up_sum))
                                      : ((duty8 > dn_lim) ? 7'(duty8 - STEP) : alvo7);
  assign ramp_down  = (duty8 > STEP) ? 7'(duty8 - STEP) : 7'd0;
  assign first_duty = (alvo8 < STEP) ? alvo7 : 7'(STEP);

  // Dwell comparisons include the period_end currently being counted.
  assign on_inc  = (on_q  == DW_SAT) ? on_q  : on_q  + 1'b1;
  assign off_inc = (off_q == DW_SAT) ? off_q : off_q + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    on_d    = on_q;
    off_d   = off_q;
    if (period_end) begin
      unique case (state_q)
        DESLIGADO: begin
          off_d = off_inc;
          if (liga && off_inc >= MIN_OFF_C) begin
            state_d = SUBINDO;
            duty_d  = first_duty;
            on_d    = '0;
          end else begin
            duty_d  = 7'd0;
          end
        end
        SUBINDO, LIGADO: begin
          on_d = on_inc;
          if (!liga && on_inc >= MIN_ON_C) begin
            state_d = DESCENDO;
            duty_d  = ramp_down;
          end else if (state_q == SUBINDO && duty8 == alvo8) begin
            state_d = LIGADO;
          end else begin
            duty_d  = toward;
          end
        end
        DESCENDO: begin
          on_d = on_inc;
          if (liga) begin
            state_d = SUBINDO;
          end else if (duty_q == 7'd0) begin
            state_d = DESLIGADO;
            off_d   = '0;
          end else begin
            duty_d  = ramp_down;
          end
        end
        default: begin
          state_d = DESLIGADO;
          duty_d  = 7'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= 7'd0;
      state_q   <= DESLIGADO;
      duty_q    <= 7'd0;
      on_q      <= '0;
      off_q     <= MIN_OFF_C;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      state_q   <= state_d;
      duty_q    <= duty_d;
      on_q      <= on_d;
      off_q     <= off_d;
      pwm_q     <= (pwm_cnt_q < duty_q) && (state_q != DESLIGADO);
    end
  end

  assign pwm_out    = pwm_q;
  assign ativo      = (state_q != DESLIGADO);
  assign bloqueado  = liga && (state_q == DESLIGADO) && (off_q < MIN_OFF_C);
  assign duty_atual = duty_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_umidificador_pwm.sv
// Bench for umidificador_pwm: directed ramp/dwell scenarios plus random liga/potencia
// segments, every cycle compared against a period-level behavioural model.
module tb_umidificador_pwm;

  localparam int MIN_ON  = 3;
  localparam int MIN_OFF = 2;
  localparam int STEP    = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       liga;
  logic [6:0] potencia;
  logic       pwm_out, ativo, bloqueado;
  logic [6:0] duty_atual;
  logic [2:0] estado;

  umidificador_pwm #(
    .TICK_DIV (1),
    .MIN_ON   (MIN_ON),
    .MIN_OFF  (MIN_OFF),
    .RAMP_STEP(STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .liga      (liga),
    .potencia  (potencia),
    .pwm_out   (pwm_out),
    .ativo     (ativo),
    .bloqueado (bloqueado),
    .duty_atual(duty_atual),
    .estado    (estado)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state/duty per PWM period, dwell as plain unbounded period counts.
  int m_state, m_duty, m_cnt, m_on, m_off, m_pwm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_duty = 0; m_cnt = 0; m_on = 0; m_off = MIN_OFF; m_pwm = 0;
  endfunction

  function automatic void model_period(input bit l, input int pot);
    int alvo;
    alvo = (pot > 100) ? 100 : pot;
    case (m_state)
      0: begin
        m_off++;
        if (l && m_off >= MIN_OFF) begin
          m_state = 1; m_duty = (alvo < STEP) ? alvo : STEP; m_on = 0;
        end else m_duty = 0;
      end
      1, 2: begin
        m_on++;
        if (!l && m_on >= MIN_ON) begin
          m_state = 3; m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
        end else if (m_state == 1 && m_duty == alvo) m_state = 2;
        else if (m_duty < alvo) m_duty = (m_duty + STEP > alvo) ? alvo : m_duty + STEP;
        else m_duty = (m_duty - STEP < alvo) ? alvo : m_duty - STEP;
      end
      default: begin
        m_on++;
        if (l) m_state = 1;
        else if (m_duty == 0) begin m_state = 0; m_off = 0; end
        else m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
      end
    endcase
  endfunction

  function automatic void model_edge(input bit l, input int pot);
    m_pwm = (m_cnt < m_duty && m_state != 0) ? 1 : 0;
    if (m_cnt == 99) model_period(l, pot);
    m_cnt = (m_cnt + 1) % 100;
  endfunction

  task automatic compare_all();
    check("pwm_out",    pwm_out,    m_pwm);
    check("ativo",      ativo,      (m_state != 0));
    check("bloqueado",  bloqueado,  (liga && m_state == 0 && m_off < MIN_OFF));
    check("duty_atual", duty_atual, m_duty);
    check("estado",     estado,     m_state);
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge(liga, int'(potencia));
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step_clk();
      highs += int'(pwm_out);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pwm"},   pwm_out,    0);
    check({tag, "_ativo"}, ativo,      0);
    check({tag, "_bloq"},  bloqueado,  0);
    check({tag, "_duty"},  duty_atual, 0);
    check({tag, "_est"},   estado,     0);
  endtask

  initial begin
    int highs;
    rst_n = 1'b0; liga = 1'b0; potencia = 7'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Start-up ramp to 60 %
    liga = 1'b1; potencia = 7'd60;
    run(100); check("up1_est", estado, 1); check("up1_duty", duty_atual, 25);
    run(100); check("up2_duty", duty_atual, 50);
    run(100); check("up3_duty", duty_atual, 60);
    run(100); check("up4_est", estado, 2);
    count_high(100, highs); check("pwm_high_60", highs, 60);

    // Ramp down, then off-dwell lockout
    liga = 1'b0;
    run(100); check("dn1_est", estado, 3); check("dn1_duty", duty_atual, 35);
    run(100); check("dn2_duty", duty_atual, 10);
    run(100); check("dn3_duty", duty_atual, 0);
    run(100); check("dn4_est", estado, 0);
    liga = 1'b1;
    #1 check("bloq_now", bloqueado, 1);
    run(100); check("bloq_pe1", bloqueado, 1); check("bloq_pe1_est", estado, 0);
    run(100); check("unlock_est", estado, 1); check("unlock_bloq", bloqueado, 0);

    // Early liga drop held by on-dwell
    run(100);
    liga = 1'b0;
    run(100); check("mindwell_est", estado, 1); check("mindwell_ativo", ativo, 1);
    run(100); check("mindwell_rel", estado, 3);
    run(400); check("off_again", estado, 0);

    // Clamp 127 -> 100, then mid-period setpoint change
    liga = 1'b1; potencia = 7'd127;
    run(100); check("clamp1", duty_atual, 25);
    run(300); check("clamp4", duty_atual, 100);
    run(100); check("clamp_est", estado, 2);
    count_high(100, highs); check("pwm_high_100", highs, 100);
    run(50); potencia = 7'd40;
    run(49); check("mid_hold", duty_atual, 100);
    run(1);  check("track1", duty_atual, 75);
    run(200); check("track3", duty_atual, 40);
    run(100); check("track_hold", duty_atual, 40);

    // Asynchronous reset in SUBINDO
    liga = 1'b0;
    run(400);
    liga = 1'b1; potencia = 7'd80;
    run(150); check("pre_rst_est", estado, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(100); check("post_rst_est", estado, 1); check("post_rst_duty", duty_atual, 25);

    // Random segments, including sub-period liga pulses
    for (int s = 0; s < 40; s++) begin
      liga     = ($urandom_range(0, 3) != 0);
      potencia = 7'($urandom_range(0, 127));
      run($urandom_range(1, 250));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
